game_timer_bcd: RTL

Countdown game timer that generates the four BCD digits (MM:SS), the `gameOver` flag and the `isStarted` flag consumed by the seven-segment display driver. It divides the board clock down to a one-second tick, counts down from a programmable start time, supports pause/resume and time bonuses, and flags game over at 00:00. The display driver blanks and blinks the digits once `gameOver` and `isStarted` are both high.

---
 rtl/game_timer_bcd.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/game_timer_bcd.sv
// Countdown game timer: one-second prescaler feeding a BCD MM:SS countdown with
// pause/resume, a saturating +10 s bonus and game-over detection at 00:00.
module game_timer_bcd #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter logic [7:0]  INIT_MM  = 8'h02,
  parameter logic [7:0]  INIT_SS  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       add_time,
  output logic [3:0] in0,
  output logic [3:0] in1,
  output logic [3:0] in2,
  output logic [3:0] in3,
  output logic       gameOver,
  output logic       isStarted,
  output logic       tick
);

  localparam int unsigned     PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [15:0]     INIT_TIME = {INIT_MM, INIT_SS};
  localparam logic [15:0]     MAX_TIME  = 16'h9959;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [15:0]   time_q, time_nx;
  logic          started_nx;
  logic          tick_now;
  logic          bonus_ok;
  logic [15:0]   time_stepped;
  logic [15:0]   time_after;

  // Digits are packed {mm_tens, mm_ones, ss_tens, ss_ones}; only called on a nonzero time.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // A carry out of 99:5x would wrap the minutes, so that case pins to 99:59.
  function automatic logic [15:0] bcd_add10(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[7:4] != 4'd5) begin
      r[7:4] = t[7:4] + 4'd1;
    end else if (t[15:8] == 8'h99) begin
      r = MAX_TIME;
    end else begin
      r[7:4] = 4'd0;
      if (t[11:8] != 4'd9) begin
        r[11:8] = t[11:8] + 4'd1;
      end else begin
        r[11:8]  = 4'd0;
        r[15:12] = t[15:12] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    tick_now     = (state == RUNNING) && (pre == PRE_LAST);
    bonus_ok     = add_time && ((state == RUNNING) || (state == PAUSED));
    time_stepped = tick_now ? bcd_dec(time_q) : time_q;
    time_after   = bonus_ok ? bcd_add10(time_stepped) : time_stepped;
  end

  always_comb begin
    state_nx   = state;
    pre_nx     = pre;
    time_nx    = time_q;
    started_nx = isStarted;
    case (state)
      IDLE: begin
        if (start) begin
          started_nx = 1'b1;
          pre_nx     = '0;
          time_nx    = INIT_TIME;
          state_nx   = (INIT_TIME == 16'h0000) ? OVER : RUNNING;
        end
      end
      RUNNING: begin
        pre_nx  = tick_now ? '0 : pre + PW'(1);
        time_nx = time_after;
        // Zero is judged after the bonus, and it outranks a coincident pause.
        if (time_after == 16'h0000) begin
          state_nx = OVER;
        end else if (pause) begin
          state_nx = PAUSED;
        end
      end
      PAUSED: begin
        time_nx = time_after;
        if (pause) begin
          state_nx = RUNNING;
        end
      end
      OVER: begin
        time_nx = 16'h0000;
        if (start) begin
          pre_nx   = '0;
          time_nx  = INIT_TIME;
          state_nx = (INIT_TIME == 16'h0000) ? OVER : RUNNING;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre       <= '0;
      time_q    <= INIT_TIME;
      gameOver  <= 1'b0;
      isStarted <= 1'b0;
      tick      <= 1'b0;
    end else begin
      state     <= state_nx;
      pre       <= pre_nx;
      time_q    <= time_nx;
      gameOver  <= (state_nx == OVER);
      isStarted <= started_nx;
      tick      <= tick_now;
    end
  end

  assign {in3, in2, in1, in0} = time_q;

endmodule
